// File: rtl/divider_pkg.sv
// Shared types and sizing for booth_divider: FSM state encoding, default width, step-counter width.
package divider_pkg;

  localparam int unsigned DEF_W = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(2 * w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_W);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from the shifted partial remainder.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  // The restored result is always below dvs, so the low W bits of the difference are exact.
  always_comb begin
    qbit     = (rem >= {1'b0, dvs});
    rem_next = qbit ? (rem[W-1:0] - dvs) : rem[W-1:0];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider (2W/W): magnitude restoring division, one bit per clock, then sign fix.
// Optional dbz/ovf flag ports are built when DIVIDER_FLAGS_EN is defined.
module booth_divider
  import divider_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] X,
  input  logic [W-1:0]   Y,
  output logic           busy,
  output logic           valid,
  output logic [2*W-1:0] Q,
  output logic [W-1:0]   R
`ifdef DIVIDER_FLAGS_EN
  ,
  output logic           dbz,
  output logic           ovf
`endif
);

  localparam int unsigned CW = cnt_width(W);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] dq;
  logic [W-1:0]   p;
  logic [W-1:0]   ay;
  logic           sign_q, sign_r, zdiv;
  logic [2*W-1:0] ax_in;
  logic [W-1:0]   ay_in;
  logic [W:0]     p_shift;
  logic [W-1:0]   p_next;
  logic           qbit;
  logic           last;
`ifdef DIVIDER_FLAGS_EN
  logic           ovf_pend;
`endif

  always_comb begin
    ax_in   = X[2*W-1] ? -X : X;
    ay_in   = Y[W-1] ? -Y : Y;
    p_shift = {p, dq[2*W-1]};
    last    = (cnt == CW'(2*W-1));
  end

  div_step #(.W(W)) u_step (
    .rem      (p_shift),
    .dvs      (ay),
    .rem_next (p_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = (Y == '0) ? FIX : DIV;
      DIV: begin
        busy = 1'b1;
        if (last) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      Q      <= '0;
      R      <= '0;
      cnt    <= '0;
      dq     <= '0;
      p      <= '0;
      ay     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      zdiv   <= 1'b0;
`ifdef DIVIDER_FLAGS_EN
      dbz      <= 1'b0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dq     <= ax_in;
          ay     <= ay_in;
          sign_q <= X[2*W-1] ^ Y[W-1];
          sign_r <= X[2*W-1];
          p      <= '0;
          cnt    <= '0;
          zdiv   <= (Y == '0);
`ifdef DIVIDER_FLAGS_EN
          dbz      <= 1'b0;
          ovf      <= 1'b0;
          ovf_pend <= (X == {1'b1, {(2*W-1){1'b0}}}) && (Y == '1);
`endif
        end
        DIV: begin
          p   <= p_next;
          dq  <= {dq[2*W-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          valid <= 1'b1;
          if (zdiv) begin
            Q <= '1;
            R <= '0;
`ifdef DIVIDER_FLAGS_EN
            dbz <= 1'b1;
`endif
          end else begin
            Q <= sign_q ? -dq : dq;
            R <= sign_r ? -p : p;
`ifdef DIVIDER_FLAGS_EN
            ovf <= ovf_pend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
